video_pattern_gen: RTL
======================

// Module: video_pattern_gen
// PURPOSE
//  Synthesizable parallel-video source: timing generator plus test-pattern engine producing di/de/hs/vs.
//  Sits directly upstream of filter stages and of the sim frame monitor, which captures a frame between vs edges.
//  Used as the deterministic stimulus source in filter benches and as an on-chip pattern source.
// PARAMETERS
//  DATA_WIDTH  8    pixel width of do_o
//  ACT_W       640  active pixels per line (>=1)
//  ACT_H       480  active lines per frame (>=1)
//  HS_W        40   hsync width, clocks (>=1)
//  HBP         40   h back porch, clocks (>=1)
//  HFP         40   h front porch, clocks (>=1)
//  VS_W        2    vsync width, lines (>=1)
//  VBP         2    v back porch, lines (>=1)
//  VFP         2    v front porch, lines (>=1)
// PORTS
//  clk           in   1           pixel clock
//  rst           in   1           synchronous reset, active-high
//  en_i          in   1           run request; frame-granular start/stop
//  pattern_i     in   2           0 x-ramp, 1 y-ramp, 2 8x8 checker, 3 solid=frame count
//  do_o          out  DATA_WIDTH  pixel data, valid when de_o=1; 0 otherwise
//  de_o          out  1           data enable
//  hs_o          out  1           hsync, active-high
//  vs_o          out  1           vsync, active-high
//  frame_done_o  out  1           1-clk pulse on last output clock of each frame
//  frcnt_o       out  16          completed-frame count, wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset: state IDLE, all counters 0, do_o/de_o/hs_o/vs_o/frame_done_o=0, frcnt_o=0. Reset mid-frame aborts it.
//  - Top FSM: IDLE -> RUN when en_i=1 sampled in IDLE; RUN -> IDLE after last clock of a frame if en_i=0 then.
//    en_i=0 mid-frame never truncates a frame. en_i=1 at frame end: next frame starts next clock, no gap.
//  - H axis phases per clock: SYNC(HS_W) -> BP(HBP) -> ACT(ACT_W) -> FP(HFP) -> SYNC. Line = HS_W+HBP+ACT_W+HFP.
//  - V axis phases advance on last clock of H FP: SYNC(VS_W) -> BP(VBP) -> ACT(ACT_H) -> FP(VFP).
//  - Frame starts at H SYNC pos 0 / V SYNC line 0. hs_o=1 in H SYNC on every line incl. vertical blanking.
//    vs_o=1 for all clocks of V SYNC lines. de_o=1 only when H ACT and V ACT.
//  - Latency: outputs registered, 1 clk after counter state; en_i sampled at cycle N in IDLE -> hs_o=vs_o=1 at N+2.
//  - Pixel (x = pixel index in line, y = active line index, both from 0):
//    0: x[DATA_WIDTH-1:0]; 1: y[DATA_WIDTH-1:0]; 2: (x[3]^y[3]) ? all-ones : 0; 3: frcnt[DATA_WIDTH-1:0].
//    Truncation, no saturation. do_o forced to 0 when de_o=0.
//  - pattern_i latched at first clock of each frame; changes mid-frame take effect next frame.
//  - frame_done_o aligned with output of last clock of V FP; frcnt_o increments on the same clock.
//  - IDLE: all video outputs 0; counters held at frame start.
// STRUCTURE
//  - video_timing_pkg: typedef enum {PH_SYNC,PH_BP,PH_ACT,PH_FP} vphase_t; typedef enum pattern_t
//    (PAT_XRAMP,PAT_YRAMP,PAT_CHECK,PAT_FRCNT); shared with timing-aware filter stages.
//  - Sub-module vtg_axis_cnt (phase FSM + position counter, step input, lengths as params),
//    instantiated twice: H stepped every clk, V stepped on H end-of-line. Top holds run FSM, pattern mux, output regs.
// TESTING (ACT_W=16 ACT_H=8 HS_W=2 HBP=3 HFP=4 VS_W=1 VBP=2 VFP=1: line 25 clk, frame 12 lines = 300 clk)
//  1 rst then en_i=1, pattern 0 -> hs_o/vs_o high 2 clk later; 8 de_o bursts of 16 per frame, do_o 0..15; monitor image 16x8.
//  2 pattern 1 -> every pixel of active line k equals k, k=0..7; hs_o pulses on all 12 lines, vs_o high for line 0 only.
//  3 pattern 2 -> each active line: pixels 0-7 = 0x00, 8-15 = 0xFF (y<8 throughout).
//  4 en_i=0 at clk 100 of frame 0 -> frame completes at clk 300, frame_done_o one pulse, frcnt_o=1, then outputs 0.
//  5 pattern_i 0->3 mid frame 0 -> frame 0 stays ramp; frame 1 all 0x01, frame 2 all 0x02, back-to-back, no gap.
//  6 rst asserted during active data -> next clk all outputs 0, frcnt_o=0; en_i still 1 -> fresh frame from SYNC.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared video timing types: axis phases, test patterns and run state.
// Used by the pattern source and timing-aware filter stages.
package video_timing_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        PH_SYNC,
        PH_BP,
        PH_ACT,
        PH_FP
    } vphase_t;

    typedef enum logic [1:0] {
        PAT_XRAMP,
        PAT_YRAMP,
        PAT_CHECK,
        PAT_FRCNT
    } pattern_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } run_state_t;

endpackage

// File: rtl/vtg_axis_cnt.sv
// One video axis: SYNC -> BP -> ACT -> FP phase FSM with a position
// counter that restarts at 0 in each phase; advances only on step.
module vtg_axis_cnt
    import video_timing_pkg::*;
#(
    parameter int SYNC_LEN = 2,
    parameter int BP_LEN   = 3,
    parameter int ACT_LEN  = 16,
    parameter int FP_LEN   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output vphase_t          phase,
    output logic [CNT_W-1:0] pos,
    output logic             last
);

    vphase_t          phase_n;
    logic [CNT_W-1:0] pos_n;
    logic [CNT_W-1:0] len;
    logic             pos_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= PH_SYNC;
            pos   <= '0;
        end else begin
            phase <= phase_n;
            pos   <= pos_n;
        end
    end

    always_comb begin
        phase_n = phase;
        pos_n   = pos;
        if (step) begin
            if (pos_last) begin
                pos_n = '0;
                unique case (phase)
                    PH_SYNC: phase_n = PH_BP;
                    PH_BP:   phase_n = PH_ACT;
                    PH_ACT:  phase_n = PH_FP;
                    PH_FP:   phase_n = PH_SYNC;
                endcase
            end else begin
                pos_n = pos + 1'b1;
            end
        end
    end

    always_comb begin
        len = '0;
        unique case (phase)
            PH_SYNC: len = CNT_W'(SYNC_LEN);
            PH_BP:   len = CNT_W'(BP_LEN);
            PH_ACT:  len = CNT_W'(ACT_LEN);
            PH_FP:   len = CNT_W'(FP_LEN);
        endcase
        pos_last = (pos == len - 1'b1);
        last     = (phase == PH_FP) && pos_last;
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Parallel-video source: frame-granular run FSM, H/V timing counters,
// test-pattern mux and registered di/de/hs/vs outputs.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACT_W      = 640,
    parameter int ACT_H      = 480,
    parameter int HS_W       = 40,
    parameter int HBP        = 40,
    parameter int HFP        = 40,
    parameter int VS_W       = 2,
    parameter int VBP        = 2,
    parameter int VFP        = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic [1:0]            pattern_i,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  frame_done_o,
    output logic [15:0]           frcnt_o
);

    run_state_t       state;
    run_state_t       state_n;
    logic             run;
    vphase_t          h_ph;
    vphase_t          v_ph;
    logic [CNT_W-1:0] h_pos;
    logic [CNT_W-1:0] v_pos;
    logic             h_end;
    logic             v_end;
    logic             frame_end;
    logic             frame_start;
    logic             act;
    pattern_t         pat_q;
    pattern_t         pat_cur;
    logic [DATA_WIDTH-1:0] pix;

    vtg_axis_cnt #(
        .SYNC_LEN(HS_W),
        .BP_LEN  (HBP),
        .ACT_LEN (ACT_W),
        .FP_LEN  (HFP)
    ) u_h (
        .clk  (clk),
        .rst  (rst),
        .step (run),
        .phase(h_ph),
        .pos  (h_pos),
        .last (h_end)
    );

    vtg_axis_cnt #(
        .SYNC_LEN(VS_W),
        .BP_LEN  (VBP),
        .ACT_LEN (ACT_H),
        .FP_LEN  (VFP)
    ) u_v (
        .clk  (clk),
        .rst  (rst),
        .step (run && h_end),
        .phase(v_ph),
        .pos  (v_pos),
        .last (v_end)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Stopping is only honoured on the last clock, so frames never truncate
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (en_i) state_n = ST_RUN;
            ST_RUN:  if (frame_end && !en_i) state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        run = (state == ST_RUN);
    end

    assign frame_end   = h_end && v_end;
    assign frame_start = (h_ph == PH_SYNC) && (h_pos == '0) &&
                         (v_ph == PH_SYNC) && (v_pos == '0);
    assign act         = (h_ph == PH_ACT) && (v_ph == PH_ACT);
    assign pat_cur     = frame_start ? pattern_t'(pattern_i) : pat_q;

    always_ff @(posedge clk) begin
        if (rst)                     pat_q <= PAT_XRAMP;
        else if (run && frame_start) pat_q <= pattern_t'(pattern_i);
    end

    always_comb begin
        pix = '0;
        unique case (pat_cur)
            PAT_XRAMP: pix = DATA_WIDTH'(h_pos);
            PAT_YRAMP: pix = DATA_WIDTH'(v_pos);
            PAT_CHECK: pix = (h_pos[3] ^ v_pos[3]) ? '1 : '0;
            PAT_FRCNT: pix = DATA_WIDTH'(frcnt_o);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            do_o         <= '0;
            de_o         <= 1'b0;
            hs_o         <= 1'b0;
            vs_o         <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            do_o         <= act ? pix : '0;
            de_o         <= act;
            hs_o         <= (h_ph == PH_SYNC);
            vs_o         <= (v_ph == PH_SYNC);
            frame_done_o <= frame_end;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                   frcnt_o <= '0;
        else if (run && frame_end) frcnt_o <= frcnt_o + 1'b1;
    end

endmodule
